// File: rtl/alarm_bank_pkg.sv
// Shared types and constants for the alarm bank.
// Holds channel mode/state enums, day length and mode decoding.
package alarm_bank_pkg;

    localparam logic [31:0] SEC_PER_DAY = 32'd86400;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ONCE  = 2'd1,
        MODE_DAILY = 2'd2
    } alarm_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZED = 2'd3
    } alarm_state_t;

    // Raw mode 3 is not a legal mode and maps to OFF.
    function automatic alarm_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_ONCE;
            2'd2:    return MODE_DAILY;
            default: return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: IDLE/ARMED/RINGING/SNOOZED FSM with stored time.
// Ports: clk, rst (sync, high), cur_time, tick, set_stb/set_time/set_mode,
//   off_stb, snooze_stb (already steered to this channel),
//   ring_next (next-cycle ringing, for the bank encoder), ring, alarm_time.
// Macro ALARM_BANK_SNOOZE_LIMIT_EN enables the per-trigger snooze limit.
module alarm_channel
    import alarm_bank_pkg::*;
#(
    parameter int RING_TIME_SEC   = 10,
    parameter int SNOOZE_TIME_SEC = 300,
    parameter int MAX_SNOOZE      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cur_time,
    input  logic        tick,
    input  logic        set_stb,
    input  logic [31:0] set_time,
    input  logic [1:0]  set_mode,
    input  logic        off_stb,
    input  logic        snooze_stb,
    output logic        ring_next,
    output logic        ring,
    output logic [31:0] alarm_time
);

    localparam int CNT_MAX = (RING_TIME_SEC > SNOOZE_TIME_SEC) ?
                             RING_TIME_SEC : SNOOZE_TIME_SEC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIME_SEC - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_TIME_SEC - 1);

    alarm_state_t     state_q, state_d;
    alarm_mode_t      mode_q, mode_d;
    logic [31:0]      time_q, time_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic             snooze_off;
    logic             finish;

`ifdef ALARM_BANK_SNOOZE_LIMIT_EN
    localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    logic [SNZ_W-1:0] snz_q, snz_d;

    // Once the limit is used up, a snooze request ends the ring instead.
    assign snooze_off = snooze_stb && (snz_q == SNZ_W'(MAX_SNOOZE));
`else
    logic unused_max_snooze;

    assign unused_max_snooze = (MAX_SNOOZE != 0);
    assign snooze_off        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            time_q  <= '0;
            sec_q   <= '0;
            ring    <= 1'b0;
`ifdef ALARM_BANK_SNOOZE_LIMIT_EN
            snz_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            time_q  <= time_d;
            sec_q   <= sec_d;
            ring    <= ring_next;
`ifdef ALARM_BANK_SNOOZE_LIMIT_EN
            snz_q   <= snz_d;
`endif
        end
    end

    // Next-state logic; priority is set > off > snooze > tick/match.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        time_d  = time_q;
        sec_d   = sec_q;
        finish  = 1'b0;
`ifdef ALARM_BANK_SNOOZE_LIMIT_EN
        snz_d   = snz_q;
`endif
        if (set_stb) begin
            mode_d = decode_mode(set_mode);
            sec_d  = '0;
`ifdef ALARM_BANK_SNOOZE_LIMIT_EN
            snz_d  = '0;
`endif
            if (mode_d == MODE_OFF) begin
                state_d = ST_IDLE;
            end else begin
                time_d  = set_time;
                state_d = ST_ARMED;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    if (tick && (cur_time == time_q))
                        state_d = ST_RINGING;
                end
                ST_RINGING: begin
                    if (off_stb || snooze_off) begin
                        finish = 1'b1;
                    end else if (snooze_stb) begin
                        state_d = ST_SNOOZED;
                        sec_d   = '0;
`ifdef ALARM_BANK_SNOOZE_LIMIT_EN
                        snz_d   = snz_q + 1'b1;
`endif
                    end else if (tick) begin
                        if (sec_q == RING_LAST)
                            finish = 1'b1;
                        else
                            sec_d = sec_q + 1'b1;
                    end
                end
                ST_SNOOZED: begin
                    if (tick) begin
                        if (sec_q == SNOOZE_LAST) begin
                            state_d = ST_RINGING;
                            sec_d   = '0;
                        end else begin
                            sec_d = sec_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (finish) begin
                sec_d = '0;
`ifdef ALARM_BANK_SNOOZE_LIMIT_EN
                snz_d = '0;
`endif
                if (mode_q == MODE_DAILY) begin
                    time_d  = time_q + SEC_PER_DAY;
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Output logic; ring is registered from ring_next above.
    always_comb begin
        ring_next  = (state_d == ST_RINGING);
        alarm_time = time_q;
    end

endmodule

// File: rtl/alarm_bank_ctrl.sv
// Bank of alarm channels with strobe steering and active-channel encoder.
// Ports: clk_i, rst_i (sync, high), cur_posix_time_i, last_tick_i,
//   set_idx_i/set_time_i/set_mode_i/set_stb_i, alarm_off_stb_i,
//   alarm_snooze_stb_i, alarm_o, active_vld_o, active_idx_o, alarm_time_o.
// Macro ALARM_BANK_SNOOZE_LIMIT_EN enables the per-trigger snooze limit.
module alarm_bank_ctrl
    import alarm_bank_pkg::*;
#(
    parameter int ALARMS_CNT      = 7,
    parameter int RING_TIME_SEC   = 10,
    parameter int SNOOZE_TIME_SEC = 300,
    parameter int MAX_SNOOZE      = 3,
    localparam int IDX_W = (ALARMS_CNT > 1) ? $clog2(ALARMS_CNT) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [31:0]                 cur_posix_time_i,
    input  logic                        last_tick_i,
    input  logic [IDX_W-1:0]            set_idx_i,
    input  logic [31:0]                 set_time_i,
    input  logic [1:0]                  set_mode_i,
    input  logic                        set_stb_i,
    input  logic                        alarm_off_stb_i,
    input  logic                        alarm_snooze_stb_i,
    output logic [ALARMS_CNT-1:0]       alarm_o,
    output logic                        active_vld_o,
    output logic [IDX_W-1:0]            active_idx_o,
    output logic [ALARMS_CNT-1:0][31:0] alarm_time_o
);

    logic [ALARMS_CNT-1:0] set_vec;
    logic [ALARMS_CNT-1:0] off_vec;
    logic [ALARMS_CNT-1:0] snz_vec;
    logic [ALARMS_CNT-1:0] ring_next;
    logic                  enc_vld;
    logic [IDX_W-1:0]      enc_idx;

    // Off/snooze reach only the channel currently reported as active.
    always_comb begin
        for (int i = 0; i < ALARMS_CNT; i++) begin
            set_vec[i] = set_stb_i && (set_idx_i == IDX_W'(i));
            off_vec[i] = alarm_off_stb_i && active_vld_o &&
                         (active_idx_o == IDX_W'(i));
            snz_vec[i] = alarm_snooze_stb_i && active_vld_o &&
                         (active_idx_o == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < ALARMS_CNT; g++) begin : g_ch
        alarm_channel #(
            .RING_TIME_SEC   (RING_TIME_SEC),
            .SNOOZE_TIME_SEC (SNOOZE_TIME_SEC),
            .MAX_SNOOZE      (MAX_SNOOZE)
        ) u_ch (
            .clk        (clk_i),
            .rst        (rst_i),
            .cur_time   (cur_posix_time_i),
            .tick       (last_tick_i),
            .set_stb    (set_vec[g]),
            .set_time   (set_time_i),
            .set_mode   (set_mode_i),
            .off_stb    (off_vec[g]),
            .snooze_stb (snz_vec[g]),
            .ring_next  (ring_next[g]),
            .ring       (alarm_o[g]),
            .alarm_time (alarm_time_o[g])
        );
    end

    // Encode the next-cycle ring vector so the registered active index
    // lines up with alarm_o in the same cycle.
    always_comb begin
        enc_vld = |ring_next;
        enc_idx = '0;
        for (int i = ALARMS_CNT - 1; i >= 0; i--) begin
            if (ring_next[i])
                enc_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_vld_o <= 1'b0;
            active_idx_o <= '0;
        end else begin
            active_vld_o <= enc_vld;
            active_idx_o <= enc_idx;
        end
    end

endmodule

// File: tb/tb_alarm_bank_ctrl.sv
// Directed self-checking bench for alarm_bank_ctrl (default parameters).
// Honours ALARM_BANK_SNOOZE_LIMIT_EN for the snooze-limit scenario.
module tb_alarm_bank_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      cur_time;
    logic             last_tick;
    logic [2:0]       set_idx;
    logic [31:0]      set_time;
    logic [1:0]       set_mode;
    logic             set_stb;
    logic             off_stb;
    logic             snz_stb;
    logic [6:0]       alarm;
    logic             act_vld;
    logic [2:0]       act_idx;
    logic [6:0][31:0] alarm_time;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alarm_bank_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cur_posix_time_i   (cur_time),
        .last_tick_i        (last_tick),
        .set_idx_i          (set_idx),
        .set_time_i         (set_time),
        .set_mode_i         (set_mode),
        .set_stb_i          (set_stb),
        .alarm_off_stb_i    (off_stb),
        .alarm_snooze_stb_i (snz_stb),
        .alarm_o            (alarm),
        .active_vld_o       (act_vld),
        .active_idx_o       (act_idx),
        .alarm_time_o       (alarm_time)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [31:0] t);
        cur_time  = t;
        last_tick = 1'b1;
        cyc();
        last_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(32'd1);
    endtask

    task automatic set(input logic [2:0] idx, input logic [31:0] t,
                       input logic [1:0] m);
        set_idx  = idx;
        set_time = t;
        set_mode = m;
        set_stb  = 1'b1;
        cyc();
        set_stb  = 1'b0;
    endtask

    task automatic off();
        off_stb = 1'b1;
        cyc();
        off_stb = 1'b0;
    endtask

    task automatic snooze();
        snz_stb = 1'b1;
        cyc();
        snz_stb = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cur_time  = '0;
        last_tick = 1'b0;
        set_idx   = '0;
        set_time  = '0;
        set_mode  = '0;
        set_stb   = 1'b0;
        off_stb   = 1'b0;
        snz_stb   = 1'b0;
        cyc();
        cyc();
        chk("rst_alarm", {25'd0, alarm}, 32'd0);
        chk("rst_vld", {31'd0, act_vld}, 32'd0);
        chk("rst_idx", {29'd0, act_idx}, 32'd0);
        chk("rst_time0", alarm_time[0], 32'd0);
        rst = 1'b0;
        cyc();

        // ONCE match on ch0
        set(3'd0, 32'd1000, 2'd1);
        chk("once_time", alarm_time[0], 32'd1000);
        tick(32'd999);
        chk("once_early", {25'd0, alarm}, 32'd0);
        tick(32'd1000);
        chk("once_ring", {25'd0, alarm}, 32'h01);
        chk("once_vld", {31'd0, act_vld}, 32'd1);
        chk("once_idx", {29'd0, act_idx}, 32'd0);
        ticks(9);
        chk("once_9", {25'd0, alarm}, 32'h01);
        ticks(1);
        chk("once_stop", {25'd0, alarm}, 32'd0);
        chk("once_stop_vld", {31'd0, act_vld}, 32'd0);
        tick(32'd1000);
        chk("once_idle", {25'd0, alarm}, 32'd0);

        // DAILY then off on ch2
        set(3'd2, 32'd5000, 2'd2);
        tick(32'd5000);
        chk("daily_ring", {25'd0, alarm}, 32'h04);
        chk("daily_idx", {29'd0, act_idx}, 32'd2);
        off();
        chk("daily_off", {25'd0, alarm}, 32'd0);
        chk("daily_time", alarm_time[2], 32'd91400);
        tick(32'd5000);
        chk("daily_old", {25'd0, alarm}, 32'd0);
        tick(32'd91400);
        chk("daily_next", {25'd0, alarm}, 32'h04);
        off();
        chk("daily_time2", alarm_time[2], 32'd177800);

        // Snooze on ch1
        set(3'd1, 32'd2000, 2'd1);
        tick(32'd2000);
        chk("snz_ring", {25'd0, alarm}, 32'h02);
        snooze();
        chk("snz_quiet", {25'd0, alarm}, 32'd0);
        chk("snz_vld", {31'd0, act_vld}, 32'd0);
        ticks(299);
        chk("snz_299", {25'd0, alarm}, 32'd0);
        ticks(1);
        chk("snz_back", {25'd0, alarm}, 32'h02);
        chk("snz_time", alarm_time[1], 32'd2000);
        for (int k = 2; k <= 3; k++) begin
            snooze();
            ticks(300);
            chk("snz_again", {25'd0, alarm}, 32'h02);
        end
        snooze();
        chk("snz_4th", {25'd0, alarm}, 32'd0);
        ticks(300);
`ifdef ALARM_BANK_SNOOZE_LIMIT_EN
        chk("snz_limit", {25'd0, alarm}, 32'd0);
`else
        chk("snz_unlim", {25'd0, alarm}, 32'h02);
        off();
`endif
        chk("snz_done", {25'd0, alarm}, 32'd0);
        snooze();
        chk("snz_ignored", {25'd0, alarm}, 32'd0);

        // Priority ch3 vs ch5
        set(3'd3, 32'd7000, 2'd1);
        set(3'd5, 32'd7000, 2'd1);
        tick(32'd7000);
        chk("pri_ring", {25'd0, alarm}, 32'h28);
        chk("pri_idx3", {29'd0, act_idx}, 32'd3);
        off();
        chk("pri_ch5", {25'd0, alarm}, 32'h20);
        chk("pri_idx5", {29'd0, act_idx}, 32'd5);
        chk("pri_vld", {31'd0, act_vld}, 32'd1);
        off();
        chk("pri_none", {25'd0, alarm}, 32'd0);

        // Off and snooze together: off wins (DAILY time advances)
        set(3'd4, 32'd8000, 2'd2);
        tick(32'd8000);
        chk("col_ring", {25'd0, alarm}, 32'h10);
        off_stb = 1'b1;
        snz_stb = 1'b1;
        cyc();
        off_stb = 1'b0;
        snz_stb = 1'b0;
        chk("col_off", {25'd0, alarm}, 32'd0);
        chk("col_time", alarm_time[4], 32'd94400);
        ticks(300);
        chk("col_nosnz", {25'd0, alarm}, 32'd0);

        // set_stb beats a match in the same cycle
        set_idx   = 3'd4;
        set_time  = 32'd123;
        set_mode  = 2'd1;
        set_stb   = 1'b1;
        cur_time  = 32'd94400;
        last_tick = 1'b1;
        cyc();
        set_stb   = 1'b0;
        last_tick = 1'b0;
        chk("col_setmatch", {25'd0, alarm}, 32'd0);
        chk("col_settime", alarm_time[4], 32'd123);

        // set OFF on a ringing channel
        set(3'd6, 32'd9000, 2'd1);
        tick(32'd9000);
        chk("set_ring", {25'd0, alarm}, 32'h40);
        chk("set_idx6", {29'd0, act_idx}, 32'd6);
        set(3'd6, 32'd0, 2'd0);
        chk("set_off", {25'd0, alarm}, 32'd0);
        chk("set_off_vld", {31'd0, act_vld}, 32'd0);
        tick(32'd9000);
        chk("set_idle", {25'd0, alarm}, 32'd0);

        // Mode 3 behaves as OFF
        set(3'd0, 32'd1234, 2'd3);
        tick(32'd1234);
        chk("mode3", {25'd0, alarm}, 32'd0);

        // Reset while ringing
        set(3'd0, 32'd3000, 2'd1);
        tick(32'd3000);
        chk("rr_ring", {25'd0, alarm}, 32'h01);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rr_alarm", {25'd0, alarm}, 32'd0);
        chk("rr_vld", {31'd0, act_vld}, 32'd0);
        chk("rr_idx", {29'd0, act_idx}, 32'd0);
        chk("rr_time0", alarm_time[0], 32'd0);
        chk("rr_time2", alarm_time[2], 32'd0);
        chk("rr_time4", alarm_time[4], 32'd0);
        tick(32'd3000);
        chk("rr_old", {25'd0, alarm}, 32'd0);
        tick(32'd0);
        chk("rr_zero", {25'd0, alarm}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_bank_ctrl.md
ALARM_BANK_CTRL -- requirements
Module: alarm_bank_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ALARMS_CNT, 7: number of alarm channels (1..32).
- RING_TIME_SEC, 10: seconds a channel rings before auto-stop.
- SNOOZE_TIME_SEC, 300: seconds a snoozed channel stays quiet.
- MAX_SNOOZE, 3: snoozes allowed per trigger (used only with the snooze limit).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1: single clock (clk_50 domain).
- rst_i, in, 1: synchronous active-high reset.
- cur_posix_time_i, in, 32: current POSIX second.
- last_tick_i, in, 1: one-cycle pulse, asserted once per second.
- set_idx_i, in, IDX_W = max(1, $clog2(ALARMS_CNT)): channel to program.
- set_time_i, in, 32: alarm POSIX time.
- set_mode_i, in, 2: OFF=0, ONCE=1, DAILY=2; 3 is treated as OFF.
- set_stb_i, in, 1: program strobe.
- alarm_off_stb_i, in, 1: off strobe.
- alarm_snooze_stb_i, in, 1: snooze strobe.
- alarm_o, out, ALARMS_CNT: per-channel ringing.
- active_vld_o, out, 1: any channel ringing.
- active_idx_o, out, IDX_W: lowest ringing index.
- alarm_time_o, out, ALARMS_CNT x 32: stored alarm times, for display.

Function
REQ-003 Each channel SHALL run an FSM with states IDLE, ARMED, RINGING and SNOOZED, and SHALL hold mode, time, a second counter and a snooze counter.
REQ-004 A set_stb_i with mode ONCE or DAILY SHALL load the time, load the mode, clear both counters and move to ARMED on the next cycle, from any state; mode OFF SHALL move to IDLE.
REQ-005 An ARMED channel SHALL enter RINGING in the cycle after a last_tick_i during which cur_posix_time_i equals its stored time exactly; there SHALL be no catch-up for past times.
REQ-006 RINGING SHALL count last_tick_i pulses; on the RING_TIME_SEC-th pulse the channel SHALL finish.
REQ-007 Finishing SHALL work as follows:
- ONCE: go to IDLE.
- DAILY: stored time += 86400 (mod 2^32) and go to ARMED.
- Both counters SHALL clear.
REQ-008 alarm_off_stb_i SHALL act only on the channel at active_idx_o, and only while active_vld_o=1; that channel SHALL finish per REQ-007. Other ringing channels SHALL be unaffected.
REQ-009 alarm_snooze_stb_i on the active channel SHALL move it to SNOOZED, clear its second counter and increment its snooze counter.
REQ-010 SNOOZED SHALL return to RINGING on the SNOOZE_TIME_SEC-th last_tick_i pulse; the stored time SHALL be unchanged.
REQ-011 Off and snooze in the same cycle: off SHALL win.
REQ-012 set_stb_i in the same cycle as a strobe or match on the same channel: set_stb_i SHALL win.
REQ-013 Strobes with active_vld_o=0 SHALL be ignored.
REQ-014 alarm_o[i] SHALL be 1 exactly in RINGING; active_idx_o SHALL be a registered priority encode (lowest index wins), 0 when none rings.
REQ-015 All outputs SHALL be registered; strobe-to-alarm_o change latency SHALL be 1 cycle.

Reset
REQ-016 On rst_i every channel SHALL go to IDLE, with mode OFF, stored time 0 and counters 0; alarm_o=0, active_vld_o=0, active_idx_o=0, alarm_time_o=0.
REQ-017 Reset mid-ring or mid-snooze SHALL discard all state with no residual output in the following cycle.

Configuration
REQ-018 Macro ALARM_BANK_SNOOZE_LIMIT_EN SHALL control the snooze limit:
- Defined: a snooze strobe when the snooze counter equals MAX_SNOOZE SHALL act as off (REQ-008).
- Undefined: snoozes SHALL be unlimited, and the snooze counter SHALL be omitted from the logic.

Structure
REQ-019 Package alarm_bank_pkg SHALL hold alarm_mode_t, alarm_state_t and SEC_PER_DAY=86400.
REQ-020 Sub-module alarm_channel SHALL implement one channel FSM; alarm_bank_ctrl SHALL instantiate ALARMS_CNT of them in a generate loop and SHALL contain the active-channel encoder and strobe steering.

Verification
REQ-021 The bench SHALL cover these scenarios:
- ONCE match: set ch0 ONCE t=1000; tick with time 1000 -> alarm_o=0000001 next cycle; after 10 more ticks alarm_o=0 and ch0 is IDLE.
- DAILY off: set ch2 DAILY t=5000; match, then off -> alarm_o[2]=0 and alarm_time_o[2]=91400; no ring at 5000 again.
- Snooze: ring ch1, snooze -> alarm_o[1]=0 for 300 ticks, then 1 again; with the macro, the 4th snooze turns it off.
- Priority: ch3 and ch5 both match at t=7000 -> active_idx_o=3; off -> ch3 stops, active_idx_o=5 next cycle, ch5 still rings.
- Collisions: off and snooze in the same cycle -> off; set_stb_i on a ringing channel with OFF -> IDLE next cycle.
- Reset while ringing: rst_i for 1 cycle -> all outputs 0; a later match on the old time produces no ring.
